// File: rtl/mac_neuron_sequencer.sv
// Time-multiplexes one MAC across N_NEURONS neurons; one result per 2*N_CHUNKS+1 cycles.
// A result stays in OUTPUT until res_ready, and no memory reads are issued during that stall.
module mac_neuron_sequencer #(
    parameter int N_STAGE   = 6,
    parameter int N_CHUNKS  = 4,
    parameter int N_NEURONS = 8,
    parameter int ACC_W     = 10,
    localparam int MW  = N_STAGE + 2,
    localparam int AW  = ($clog2(N_NEURONS * N_CHUNKS) > 0) ? $clog2(N_NEURONS * N_CHUNKS) : 1,
    localparam int XW  = ($clog2(N_CHUNKS) > 0) ? $clog2(N_CHUNKS) : 1,
    localparam int NW  = ($clog2(N_NEURONS) > 0) ? $clog2(N_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [AW-1:0]           w_addr,
    output logic [XW-1:0]           x_addr,
    input  logic signed [MW-1:0]    mac_y,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic [NW-1:0]           res_idx
);

    // Wide enough for N_CHUNKS full-scale MAC results, so the running sum never wraps.
    localparam int AIW     = MW + $clog2(N_CHUNKS) + 1;
    localparam int SAT_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (ACC_W - 1));
    localparam logic [XW-1:0] LAST_CHUNK  = XW'(N_CHUNKS - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, ACCUM, OUTPUT} state_t;

    state_t                 state;
    logic [XW-1:0]          chunk;
    logic [NW-1:0]          neuron;
    logic signed [AIW-1:0]  acc;
    logic signed [AIW-1:0]  acc_sum;
    int                     sum_w;
    logic signed [ACC_W-1:0] res_next;

    function automatic logic [AW-1:0] row_addr(input int n, input int c);
        return AW'(n * N_CHUNKS + c);
    endfunction

    always_comb begin
        acc_sum  = acc + {{(AIW - MW){mac_y[MW-1]}}, mac_y};
        sum_w    = int'(acc_sum);
        res_next = sum_w[ACC_W-1:0];
        if (sum_w > SAT_MAX)
            res_next = ACC_W'(SAT_MAX);
        else if (sum_w < SAT_MIN)
            res_next = ACC_W'(SAT_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chunk     <= '0;
            neuron    <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        neuron    <= '0;
                        chunk     <= '0;
                        acc       <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        w_addr    <= '0;
                        x_addr    <= '0;
                    end
                end
                FETCH: begin
                    state     <= ACCUM;
                    mem_rd_en <= 1'b0;
                end
                ACCUM: begin
                    acc <= acc_sum;
                    if (chunk == LAST_CHUNK) begin
                        state     <= OUTPUT;
                        res_valid <= 1'b1;
                        res_data  <= res_next;
                        res_idx   <= neuron;
                    end else begin
                        state     <= FETCH;
                        chunk     <= chunk + XW'(1);
                        mem_rd_en <= 1'b1;
                        w_addr    <= row_addr(int'(neuron), int'(chunk) + 1);
                        x_addr    <= chunk + XW'(1);
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (neuron == LAST_NEURON) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            neuron    <= neuron + NW'(1);
                            chunk     <= '0;
                            acc       <= '0;
                            mem_rd_en <= 1'b1;
                            w_addr    <= row_addr(int'(neuron) + 1, 0);
                            x_addr    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
